inst_loader: RTL
================

Name: inst_loader

Overview:
- Writes program images into the instruction memory before the core runs; it is the write side of instruction memory, and the fetch path is the read side.
- Accepts a valid/ready stream of W-bit machine words, one per beat, and writes them to consecutive addresses starting at 0.
- Loading stops at the halt word (all ones). The rest of memory is optionally zero-filled, then the core is released via CoreRun.

Parameters:
A, 10, instruction memory address bits (depth 2**A)
W, 9, instruction word width
FILL_REST, 1, 1 = after halt, write 0 (no-op) to every remaining address; 0 = stop at halt

Ports:
Clk  input  1  single clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
Start  input  1  one-cycle request to begin a new load
InValid  input  1  InData holds a valid word
InData  input  W  program word
InReady  output  1  loader accepts InData this cycle
WrEn  output  1  instruction memory write enable
WrAddr  output  A  instruction memory write address
WrData  output  W  instruction memory write data
Busy  output  1  state is LOAD or FILL
Done  output  1  load finished cleanly; sticky until next Start
Error  output  1  overflow (memory full, no halt seen); sticky until next Start
CoreRun  output  1  core may fetch; high only in DONE, rises one cycle after Done
WordCount  output  A+1  number of stream words accepted in the current load

Behaviour:
- Reset (async, Reset_n=0): state IDLE; addr counter 0; WrEn, WrAddr, WrData, Done, Error, CoreRun, Busy, InReady, WordCount all 0. Memory contents are not touched. Reset mid-load abandons the load with no further writes.
- Handshake: a word is accepted on a rising edge when InValid&&InReady. InData may change freely while InReady=0.
- Write outputs are registered: the word accepted at edge N produces WrEn=1, WrAddr=addr, WrData=word during cycle N..N+1. The memory commits it at edge N+1. WrEn is 0 in every cycle without a write.
- States:
  - IDLE: InReady=0. Start=1 -> LOAD; addr=0, WordCount=0, Done=0, Error=0.
  - LOAD: InReady=1; Busy=1. On accept: write the word at addr, WordCount++.
    - Word == all ones (halt): if FILL_REST=1 and addr != 2**A-1 -> FILL with addr+1; otherwise -> DONE.
    - Non-halt word at addr == 2**A-1: the word is written, then -> ERR.
    - Otherwise addr++ and stay in LOAD.
  - FILL: InReady=0; Busy=1. Each cycle write 0 at addr, then addr++. The write at addr == 2**A-1 -> DONE. This takes exactly 2**A-1-(halt addr) cycles.
  - DONE: Done=1. CoreRun=1 from the second cycle in DONE, so the last write is committed before fetch starts. Start=1 -> LOAD; Done, CoreRun and WordCount clear on the same edge.
  - ERR: Error=1, CoreRun=0. Start=1 -> LOAD.
- Start is ignored in LOAD and FILL.
- Addresses never wrap: addr saturates at 2**A-1, and the loader never writes address 0 twice within one load.
- WordCount is A+1 bits so that a full 2**A-word load (halt in the last slot) reports 2**A.
- Done and Error are never both 1.

Decomposition:
- Shared package (proc_pkg):
  - state enum loader_state_t {IDLE, LOAD, FILL, DONE, ERR}
  - constant HALT_WORD = all ones of width W
  - constant NOP_WORD = 0
  - These are reused by the fetch/halt-detect logic.
- One natural sub-module, loader_addr_ctr: addr register with load-zero, increment and last-address flag. Everything else stays in inst_loader.

Test Plan:
- A=10, FILL_REST=0; stream 000_001_100, 000_101_000, 010_101_010, 1_1111_1111 -> writes at addresses 0..3 with those values; Done=1, WordCount=4; CoreRun rises the cycle after Done; no write to address 4.
- A=4, FILL_REST=1; stream 3 words, halt at address 2 -> 13 zero writes at addresses 3..15 with InReady=0 throughout; then Done=1.
- A=4; 16 non-halt words -> all 16 written; Error=1, Done=0, CoreRun=0, WordCount=16. Then Start -> back in LOAD with Error cleared.
- Backpressure: InValid toggles 1,0,0,1,... with InData changing while invalid -> only valid beats are written, addresses stay contiguous, WrEn never asserts in idle cycles.
- Reset_n pulled low in the middle of LOAD (after 5 words) -> all outputs 0 immediately without waiting for a clock, no further writes. A subsequent Start restarts at address 0.
- Start pulsed during LOAD and during FILL -> ignored; WordCount and addr continue unchanged.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions used by the instruction loader and by the
// fetch/halt-detect logic.
//   loader_state_t : loader FSM states
//   HALT_WORD      : all-ones halt opcode; slice [W-1:0] for a W-bit word
//   NOP_WORD       : all-zeros no-op; slice [W-1:0] for a W-bit word
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    DONE,
    ERR
  } loader_state_t;

  // Word width is a per-instance parameter, so the constants are kept at a
  // generous maximum width and sliced down by the user.
  localparam int unsigned MAX_WORD_W = 64;
  localparam logic [MAX_WORD_W-1:0] HALT_WORD = '1;
  localparam logic [MAX_WORD_W-1:0] NOP_WORD  = '0;

endpackage

// File: rtl/inst_loader_if.sv
// Program word stream into the instruction loader (valid/ready).
//   InValid : source has a word on InData
//   InData  : W-bit program word
//   InReady : loader accepts InData this cycle
// master = word source, slave = loader.
interface inst_loader_if #(
  parameter int unsigned W = 9
) ();

  logic         InValid;
  logic [W-1:0] InData;
  logic         InReady;

  modport master (
    output InValid,
    output InData,
    input  InReady
  );

  modport slave (
    input  InValid,
    input  InData,
    output InReady
  );

endinterface

// File: rtl/loader_addr_ctr.sv
// Instruction memory write-address counter for the loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : load zero (takes priority over inc)
//   inc        : advance by one; saturates at the last address
//   addr       : current address
//   last       : addr is the last memory location (2**A-1)
module loader_addr_ctr #(
  parameter int unsigned A = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [A-1:0] addr,
  output logic         last
);

  assign last = (addr == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc && !last) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: write side of instruction memory. Takes a stream of
// program words, writes them from address 0 upward, stops at the halt word,
// optionally zero-fills the rest of memory, then releases the core.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   Start        : one-cycle request to begin a new load (IDLE/DONE/ERR only)
//   stream       : program word stream (slave side)
//   WrEn/WrAddr/WrData : registered instruction memory write port
//   Busy         : loading or zero-filling
//   Done         : load finished cleanly (sticky until Start)
//   Error        : memory filled without a halt word (sticky until Start)
//   CoreRun      : core may fetch; rises one cycle after Done
//   WordCount    : stream words accepted in the current load
module inst_loader
  import proc_pkg::*;
#(
  parameter int unsigned A         = 10,
  parameter int unsigned W         = 9,
  parameter bit          FILL_REST = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  inst_loader_if.slave stream,
  output logic         WrEn,
  output logic [A-1:0] WrAddr,
  output logic [W-1:0] WrData,
  output logic         Busy,
  output logic         Done,
  output logic         Error,
  output logic         CoreRun,
  output logic [A:0]   WordCount
);

  loader_state_t state;

  logic [A-1:0] addr;
  logic         addr_last;
  logic         addr_clr;
  logic         addr_inc;
  logic         accept;
  logic         is_halt;
  logic         start_load;

  // Status outputs are pure decodes of the state register.
  assign stream.InReady = (state == LOAD);
  assign Busy           = (state == LOAD) || (state == FILL);
  assign Done           = (state == DONE);
  assign Error          = (state == ERR);

  assign accept     = stream.InValid && (state == LOAD);
  assign is_halt    = (stream.InData == HALT_WORD[W-1:0]);
  assign start_load = Start && ((state == IDLE) || (state == DONE) || (state == ERR));

  always_comb begin
    addr_clr = start_load;
    addr_inc = 1'b0;
    unique case (state)
      LOAD:    addr_inc = accept && (!is_halt || FILL_REST);
      FILL:    addr_inc = 1'b1;
      default: addr_inc = 1'b0;
    endcase
  end

  loader_addr_ctr #(
    .A (A)
  ) u_addr_ctr (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (addr_clr),
    .inc   (addr_inc),
    .addr  (addr),
    .last  (addr_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      CoreRun   <= 1'b0;
      WordCount <= '0;
    end else begin
      WrEn <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            state     <= LOAD;
            WordCount <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            WrEn      <= 1'b1;
            WrAddr    <= addr;
            WrData    <= stream.InData;
            WordCount <= WordCount + 1'b1;
            if (is_halt) begin
              state <= (FILL_REST && !addr_last) ? FILL : DONE;
            end else if (addr_last) begin
              state <= ERR;
            end
          end
        end
        FILL: begin
          WrEn   <= 1'b1;
          WrAddr <= addr;
          WrData <= NOP_WORD[W-1:0];
          if (addr_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          // CoreRun lags Done by one cycle so the final write has been
          // committed before the core fetches.
          if (Start) begin
            state     <= LOAD;
            WordCount <= '0;
            CoreRun   <= 1'b0;
          end else begin
            CoreRun <= 1'b1;
          end
        end
        ERR: begin
          if (Start) begin
            state     <= LOAD;
            WordCount <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
